// File: rtl/binary_th_ctl.sv
// binary_th_ctl: per-frame mean-luma threshold controller with serial restoring divider.
// Optional hysteresis on threshold writes is enabled by defining BIN_TH_HYST_EN.
module binary_th_ctl #(
    parameter int          ACC_W      = 32,
    parameter int          CNT_W      = 24,
    parameter logic [7:0]  DEFAULT_TH = 8'd128,
    parameter logic [7:0]  HYST       = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_y,
    input  logic       in_vsync,
    input  logic       in_en,
    input  logic       manual_sel,
    input  logic [7:0] manual_th,
    output logic [7:0] threshold,
    output logic [7:0] frame_mean,
    output logic       th_valid,
    output logic       busy,
    output logic       overrun
);
    typedef enum logic [1:0] {IDLE, DIV, UPD} state_t;
    localparam int CYC_W = $clog2(ACC_W);

    state_t           state_q;
    logic             vs_q, fe;
    logic [ACC_W-1:0] acc_q, acc_d, num_q, num_d, den_q, rem_q, rem_d;
    logic [ACC_W:0]   acc_sum, rem_sh, rem_sub;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CYC_W-1:0] cyc_q;
    logic [7:0]       th_q, mean_q, mean_d, diff;
    logic             th_valid_q, busy_q, overrun_q, ge, wr_th;

    assign fe = ~in_vsync & vs_q;

    // Saturating accumulation; the pixel in the frame-end cycle opens the new frame.
    assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(in_y);
    assign acc_d = fe ? (in_en ? ACC_W'(in_y) : '0)
                      : in_en ? (acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0]) : acc_q;
    assign cnt_d = fe ? (in_en ? CNT_W'(1) : '0)
                      : in_en ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : cnt_q;

    // One restoring step: numerator shifts out MSB first, quotient bits shift in.
    assign rem_sh  = {rem_q, num_q[ACC_W-1]};
    assign rem_sub = rem_sh - {1'b0, den_q};
    assign ge      = rem_sh >= {1'b0, den_q};
    assign rem_d   = ge ? rem_sub[ACC_W-1:0] : rem_sh[ACC_W-1:0];
    assign num_d   = {num_q[ACC_W-2:0], ge};
    assign mean_d  = |num_d[ACC_W-1:8] ? 8'hff : num_d[7:0];
    assign diff    = mean_d >= th_q ? mean_d - th_q : th_q - mean_d;

`ifdef BIN_TH_HYST_EN
    assign wr_th = diff >= HYST;
`else
    logic unused_hyst;
    assign unused_hyst = ^{HYST, diff};
    assign wr_th = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vs_q       <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            num_q      <= '0;
            den_q      <= '0;
            rem_q      <= '0;
            cyc_q      <= '0;
            th_q       <= DEFAULT_TH;
            mean_q     <= 8'd0;
            th_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            vs_q       <= in_vsync;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            th_valid_q <= 1'b0;
            if (fe && state_q != IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (fe) begin
                    // An empty frame keeps both mean and threshold as they are.
                    if (cnt_q == '0) begin
                        state_q    <= UPD;
                        th_valid_q <= 1'b1;
                    end else begin
                        state_q <= DIV;
                        busy_q  <= 1'b1;
                        num_q   <= acc_q;
                        den_q   <= ACC_W'(cnt_q);
                        rem_q   <= '0;
                        cyc_q   <= '0;
                    end
                end
                DIV: begin
                    num_q <= num_d;
                    rem_q <= rem_d;
                    cyc_q <= cyc_q + 1'b1;
                    if (cyc_q == CYC_W'(ACC_W-1)) begin
                        state_q    <= UPD;
                        busy_q     <= 1'b0;
                        th_valid_q <= 1'b1;
                        mean_q     <= mean_d;
                        if (!manual_sel && wr_th)
                            th_q <= mean_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (manual_sel)
                th_q <= manual_th;
        end
    end

    assign threshold  = th_q;
    assign frame_mean = mean_q;
    assign th_valid   = th_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
endmodule
